array_ref_sched: RTL and testbench

Refresh scheduler between the read/write frame arbiter and the memory array port. Forwards merged array frames unchanged, counts a programmable refresh interval, and inserts array refresh handshakes only at frame boundaries, so a burst delimited by sof/eof is never split. Deferred refreshes are tracked in a saturating pending counter.

---
 rtl/array_ref_pkg.sv | 40 ++++
 rtl/array_ref_sched_if.sv | 15 +
 rtl/array_ref_timer.sv | 87 ++++++++
 rtl/array_ref_sched.sv | 139 +++++++++++++
 tb/tb_array_ref_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_ref_pkg.sv
// Shared definitions for the array refresh scheduler: frame geometry,
// frame bit positions, the scheduler state encoding and counter widths.
package array_ref_pkg;

   localparam int unsigned ARRAY_COL_ADDR_WIDTH   = 6;
   localparam int unsigned ARRAY_ROW_ADDR_WIDTH   = 16;
   localparam int unsigned ARRAY_DATA_WIDTH       = 64;
   localparam int unsigned ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH +
                                                    ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH;

   // Flat bit positions of the frame control flags
   localparam int unsigned WR_BIT  = 86;
   localparam int unsigned SOF_BIT = 87;
   localparam int unsigned EOF_BIT = 88;

   localparam int unsigned REF_PEND_MAX_DFLT = 8;
   localparam int unsigned REF_PEND_W        = 4;
   localparam int unsigned REF_INTERVAL_W    = 16;
   localparam int unsigned REF_GAP_W         = 4;
   localparam int unsigned REF_DONE_W        = 16;
   localparam int unsigned REF_DROP_W        = 8;

   // Array frame beat, MSB first so the flags land on WR_BIT/SOF_BIT/EOF_BIT
   typedef struct packed {
      logic                            eof;
      logic                            sof;
      logic                            wr;
      logic [ARRAY_COL_ADDR_WIDTH-1:0] col;
      logic [ARRAY_ROW_ADDR_WIDTH-1:0] row;
      logic [ARRAY_DATA_WIDTH-1:0]     data;
   } array_frame_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_XFER    = 2'd1,
      ST_REF_REQ = 2'd2,
      ST_REF_GAP = 2'd3
   } ref_state_e;

endpackage

// File: rtl/array_ref_sched_if.sv
// Valid/ready array frame channel.
//   valid : beat valid (master -> slave)
//   ready : beat accepted (slave -> master)
//   data  : array frame beat (master -> slave)
interface array_ref_sched_if;
   import array_ref_pkg::*;

   logic         valid;
   logic         ready;
   array_frame_t data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/array_ref_timer.sv
// Refresh interval timer and pending-refresh bookkeeping.
//   clk, rst         : clock, synchronous active-high reset
//   mc_en            : controller enable, gates the interval counter
//   ref_interval     : cycles between ticks, 0 disables ticking
//   ack_acc          : a refresh handshake completed this cycle
//   ref_pending      : saturating count of owed refreshes
//   ref_ovf          : sticky, a tick was dropped at saturation
//   ref_done_cnt     : (ARRAY_REF_STATS_EN) accepted acks, wrapping
//   ref_drop_cnt     : (ARRAY_REF_STATS_EN) dropped ticks, saturating
module array_ref_timer
   import array_ref_pkg::*;
#(
   parameter int unsigned PEND_MAX = REF_PEND_MAX_DFLT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mc_en,
   input  logic [REF_INTERVAL_W-1:0] ref_interval,
   input  logic                      ack_acc,
   output logic [REF_PEND_W-1:0]     ref_pending,
   output logic                      ref_ovf
`ifdef ARRAY_REF_STATS_EN
   ,
   output logic [REF_DONE_W-1:0]     ref_done_cnt,
   output logic [REF_DROP_W-1:0]     ref_drop_cnt
`endif
);

   logic [REF_INTERVAL_W-1:0] int_cnt;
   logic                      cnt_en;
   logic                      tick;
   logic                      at_max;
   logic                      drop;

   assign cnt_en = mc_en & (ref_interval != '0);
   // >= keeps the counter from running away if the interval shrinks mid-count
   assign tick   = cnt_en & (int_cnt >= (ref_interval - REF_INTERVAL_W'(1)));
   assign at_max = (ref_pending == REF_PEND_W'(PEND_MAX));
   // a simultaneous ack makes room, so only an unmatched tick at the limit is lost
   assign drop   = tick & ~ack_acc & at_max;

   // Interval counter
   always_ff @(posedge clk) begin
      if (rst) begin
         int_cnt <= '0;
      end else if (!cnt_en || tick) begin
         int_cnt <= '0;
      end else begin
         int_cnt <= int_cnt + REF_INTERVAL_W'(1);
      end
   end

   // Pending count and overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_pending <= '0;
         ref_ovf     <= 1'b0;
      end else begin
         if (tick && !ack_acc && !at_max) begin
            ref_pending <= ref_pending + REF_PEND_W'(1);
         end else if (ack_acc && !tick) begin
            ref_pending <= ref_pending - REF_PEND_W'(1);
         end
         if (drop) begin
            ref_ovf <= 1'b1;
         end
      end
   end

`ifdef ARRAY_REF_STATS_EN
   // Refresh statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_done_cnt <= '0;
         ref_drop_cnt <= '0;
      end else begin
         if (ack_acc) begin
            ref_done_cnt <= ref_done_cnt + REF_DONE_W'(1);
         end
         if (drop && (ref_drop_cnt != '1)) begin
            ref_drop_cnt <= ref_drop_cnt + REF_DROP_W'(1);
         end
      end
   end
`endif

endmodule

// File: rtl/array_ref_sched.sv
// Refresh scheduler between the frame arbiter and the memory array port.
// Frames pass through combinationally; refresh handshakes are inserted only
// between frames so a sof..eof burst is never split.
// Optional feature macro: ARRAY_REF_STATS_EN (adds ref_done_cnt/ref_drop_cnt).
//   clk, rst                : clock, synchronous active-high reset
//   arb2sched_frame         : upstream frame channel (slave side)
//   sched2array_frame       : downstream frame channel (master side)
//   sched2array_ref_req     : refresh request level
//   array2sched_ref_ack     : refresh accepted
//   mc_en                   : controller enable
//   ref_interval            : cycles between refresh ticks, 0 disables
//   ref_gap                 : idle cycles after each ack
//   ref_pending, ref_ovf    : pending count, sticky drop flag
//   ref_done_cnt/drop_cnt   : (ARRAY_REF_STATS_EN) statistics
module array_ref_sched
   import array_ref_pkg::*;
#(
   parameter int unsigned REF_PEND_MAX = REF_PEND_MAX_DFLT
) (
   input  logic                      clk,
   input  logic                      rst,
   array_ref_sched_if.slave          arb2sched_frame,
   array_ref_sched_if.master         sched2array_frame,
   output logic                      sched2array_ref_req,
   input  logic                      array2sched_ref_ack,
   input  logic                      mc_en,
   input  logic [REF_INTERVAL_W-1:0] ref_interval,
   input  logic [REF_GAP_W-1:0]      ref_gap,
   output logic [REF_PEND_W-1:0]     ref_pending,
   output logic                      ref_ovf
`ifdef ARRAY_REF_STATS_EN
   ,
   output logic [REF_DONE_W-1:0]     ref_done_cnt,
   output logic [REF_DROP_W-1:0]     ref_drop_cnt
`endif
);

   ref_state_e           state;
   ref_state_e           state_nxt;
   logic [REF_GAP_W-1:0] gap_cnt;
   logic                 pass_en;
   logic                 up_hs;
   logic                 ack_acc;
   logic                 pend_nz;
   logic                 gap_done;

   assign pend_nz  = (ref_pending != '0);
   assign up_hs    = arb2sched_frame.valid & sched2array_frame.ready & pass_en;
   // an ack only counts while the request is actually raised
   assign ack_acc  = sched2array_ref_req & array2sched_ref_ack;
   assign gap_done = (({1'b0, gap_cnt} + (REF_GAP_W+1)'(1)) >= {1'b0, ref_gap});

   // Zero-latency pass-through, no buffering
   assign sched2array_frame.valid = arb2sched_frame.valid & pass_en;
   assign arb2sched_frame.ready   = sched2array_frame.ready & pass_en;
   assign sched2array_frame.data  = arb2sched_frame.data;

   array_ref_timer #(
      .PEND_MAX     (REF_PEND_MAX)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .mc_en        (mc_en),
      .ref_interval (ref_interval),
      .ack_acc      (ack_acc),
      .ref_pending  (ref_pending),
      .ref_ovf      (ref_ovf)
`ifdef ARRAY_REF_STATS_EN
      ,
      .ref_done_cnt (ref_done_cnt),
      .ref_drop_cnt (ref_drop_cnt)
`endif
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Post-refresh gap counter, cleared whenever not in the gap
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (state == ST_REF_GAP) begin
         gap_cnt <= gap_cnt + REF_GAP_W'(1);
      end else begin
         gap_cnt <= '0;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            // owed refresh wins over a sof presented in the same cycle
            if (pend_nz) begin
               state_nxt = ST_REF_REQ;
            end else if (up_hs && !arb2sched_frame.data.eof) begin
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (up_hs && arb2sched_frame.data.eof) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_REF_REQ: begin
            if (array2sched_ref_ack) begin
               state_nxt = (ref_gap == '0) ? ST_IDLE : ST_REF_GAP;
            end
         end
         ST_REF_GAP: begin
            if (gap_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State decode outputs
   always_comb begin
      pass_en             = 1'b0;
      sched2array_ref_req = 1'b0;
      unique case (state)
         ST_IDLE:    pass_en = mc_en & ~pend_nz;
         ST_XFER:    pass_en = 1'b1;
         ST_REF_REQ: sched2array_ref_req = 1'b1;
         ST_REF_GAP: pass_en = 1'b0;
         default:    pass_en = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_array_ref_sched.sv
module tb_array_ref_sched;
   import array_ref_pkg::*;

   localparam int unsigned PMAX = 8;
   localparam int unsigned FW   = ARRAY_FRAME_DATA_WIDTH;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req;
   logic        ack = 1'b0;
   logic        mc_en = 1'b0;
   logic [15:0] interval = '0;
   logic [3:0]  gap = '0;
   logic [3:0]  pend;
   logic        ovf;
`ifdef ARRAY_REF_STATS_EN
   logic [15:0] done_cnt;
   logic [7:0]  drop_cnt;
`endif

   array_ref_sched_if up_if ();
   array_ref_sched_if dn_if ();

   always #5 clk = ~clk;

   array_ref_sched #(.REF_PEND_MAX(PMAX)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .arb2sched_frame     (up_if.slave),
      .sched2array_frame   (dn_if.master),
      .sched2array_ref_req (req),
      .array2sched_ref_ack (ack),
      .mc_en               (mc_en),
      .ref_interval        (interval),
      .ref_gap             (gap),
      .ref_pending         (pend),
      .ref_ovf             (ovf)
`ifdef ARRAY_REF_STATS_EN
      ,
      .ref_done_cnt        (done_cnt),
      .ref_drop_cnt        (drop_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // reference model: frame/refresh phases tracked as plain integers and flags
   int m_cnt, m_pend, m_gap_left, m_done, m_drop;
   bit m_ovf, m_in_frame, m_busy;
   bit model_on = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] rnd_frame(input bit sof, input bit eof);
      logic [FW-1:0] f;
      f = FW'({$urandom(), $urandom(), $urandom()});
      f[SOF_BIT] = sof;
      f[EOF_BIT] = eof;
      return f;
   endfunction

   function automatic bit m_idle();
      return !m_in_frame && !m_busy && (m_gap_left == 0);
   endfunction

   function automatic bit m_pass();
      return m_in_frame || (m_idle() && (m_pend == 0) && (mc_en == 1'b1));
   endfunction

   task automatic check_model();
      bit p;
      p = m_pass();
      chk("up_ready", 128'(up_if.ready), 128'(dn_if.ready & p));
      chk("dn_valid", 128'(dn_if.valid), 128'(up_if.valid & p));
      chk("dn_data", 128'(dn_if.data), 128'(up_if.data));
      chk("ref_req", 128'(req), 128'(m_busy));
      chk("ref_pending", 128'(pend), 128'(m_pend));
      chk("ref_ovf", 128'(ovf), 128'(m_ovf));
`ifdef ARRAY_REF_STATS_EN
      chk("ref_done_cnt", 128'(done_cnt), 128'(m_done));
      chk("ref_drop_cnt", 128'(drop_cnt), 128'(m_drop));
`endif
   endtask

   task automatic step_model();
      bit            idle, hs, tick, ack_ok, eof;
      int            ivl;
      logic [FW-1:0] b;
      if (rst) begin
         m_cnt = 0; m_pend = 0; m_gap_left = 0; m_done = 0; m_drop = 0;
         m_ovf = 0; m_in_frame = 0; m_busy = 0;
         return;
      end
      b      = up_if.data;
      eof    = b[EOF_BIT];
      idle   = m_idle();
      hs     = up_if.valid && dn_if.ready && m_pass();
      ivl    = int'(interval);
      tick   = mc_en && (ivl != 0) && (m_cnt == ivl - 1);
      ack_ok = m_busy && ack;
      if (!(mc_en && ivl != 0) || tick) m_cnt = 0;
      else m_cnt++;
      if (idle) begin
         if (m_pend > 0) m_busy = 1;
         else if (hs && !eof) m_in_frame = 1;
      end else if (m_in_frame) begin
         if (hs && eof) m_in_frame = 0;
      end else if (m_busy) begin
         if (ack) begin m_busy = 0; m_gap_left = int'(gap); end
      end else begin
         m_gap_left--;
      end
      if (ack_ok) m_done = (m_done + 1) % 65536;
      if (tick && !ack_ok) begin
         if (m_pend == PMAX) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
         end else begin
            m_pend++;
         end
      end else if (ack_ok && !tick) begin
         m_pend--;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (model_on) check_model();
      step_model();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mc_en = 1'b0; ack = 1'b0; interval = '0; gap = '0;
      up_if.valid = 1'b0; dn_if.ready = 1'b0;
      cycle(); cycle();
      rst = 1'b0;
   endtask

   typedef struct {
      bit mc; bit v; bit r; bit sof; bit eof;
      bit exp_v; bit exp_r;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      int   n;

      up_if.valid = 1'b0;
      up_if.data  = '0;
      dn_if.ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step_model();
      model_on = 1'b1;

      // reset values
      chk("rst_req", 128'(req), 128'(0));
      chk("rst_pending", 128'(pend), 128'(0));
      chk("rst_ovf", 128'(ovf), 128'(0));
      do_reset();

      // pass-through gating with ticks disabled
      tbl[0]  = '{0, 1, 1, 1, 0, 0, 0};  // mc_en=0 blocks a new frame
      tbl[1]  = '{1, 1, 0, 1, 0, 1, 0};  // downstream not ready
      tbl[2]  = '{1, 1, 1, 1, 0, 1, 1};  // sof accepted -> in frame
      tbl[3]  = '{0, 1, 1, 0, 0, 1, 1};  // frame continues with mc_en=0
      tbl[4]  = '{0, 0, 1, 0, 0, 0, 1};  // bubble inside frame
      tbl[5]  = '{0, 1, 1, 0, 1, 1, 1};  // eof ends frame
      tbl[6]  = '{0, 1, 1, 1, 0, 0, 0};  // blocked again
      tbl[7]  = '{1, 1, 1, 1, 1, 1, 1};  // single-beat frame
      tbl[8]  = '{1, 0, 1, 0, 0, 0, 1};  // still idle
      tbl[9]  = '{1, 1, 1, 1, 0, 1, 1};  // new frame
      tbl[10] = '{1, 1, 1, 0, 1, 1, 1};  // its eof
      for (int i = 0; i < 11; i++) begin
         mc_en       = tbl[i].mc;
         up_if.valid = tbl[i].v;
         dn_if.ready = tbl[i].r;
         up_if.data  = rnd_frame(tbl[i].sof, tbl[i].eof);
         #1;
         chk($sformatf("tbl%0d_dn_valid", i), 128'(dn_if.valid), 128'(tbl[i].exp_v));
         chk($sformatf("tbl%0d_up_ready", i), 128'(up_if.ready), 128'(tbl[i].exp_r));
         chk($sformatf("tbl%0d_req", i), 128'(req), 128'(0));
         cycle();
      end

      // interval 20: request timing, delayed ack, 3-cycle gap
      do_reset();
      interval = 16'd20; gap = 4'd3; mc_en = 1'b1; dn_if.ready = 1'b1;
      n = 0;
      while (!req && n < 40) begin cycle(); n++; end
      chk("req_rise_cycles", 128'(n), 128'(21));
      cycle(); cycle();
      chk("req_held", 128'(req), 128'(1));
      ack = 1'b1;
      cycle();
      ack = 1'b0;
      chk("req_fall", 128'(req), 128'(0));
      chk("pend_drained", 128'(pend), 128'(0));
      up_if.valid = 1'b1;
      up_if.data  = rnd_frame(1'b1, 1'b1);
      for (int g = 0; g < 3; g++) begin
         #1;
         chk($sformatf("gap%0d_ready", g), 128'(up_if.ready), 128'(0));
         cycle();
      end
      #1;
      chk("gap_end_ready", 128'(up_if.ready), 128'(1));
      cycle();
      up_if.valid = 1'b0;

      // tick inside an 8-beat frame: burst stays contiguous
      do_reset();
      interval = 16'd3; mc_en = 1'b1; dn_if.ready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         up_if.valid = 1'b1;
         up_if.data  = rnd_frame(b == 0, b == 7);
         #1;
         chk($sformatf("burst%0d_ready", b), 128'(up_if.ready), 128'(1));
         chk($sformatf("burst%0d_req", b), 128'(req), 128'(0));
         cycle();
      end
      up_if.valid = 1'b0;
      chk("post_eof_req", 128'(req), 128'(0));
      cycle();
      chk("post_eof_req_next", 128'(req), 128'(1));

      // saturation then back-to-back drain
      do_reset();
      interval = 16'd4; gap = 4'd0; mc_en = 1'b1;
      repeat (45) cycle();
      chk("sat_pending", 128'(pend), 128'(PMAX));
      chk("sat_ovf", 128'(ovf), 128'(1));
      mc_en = 1'b0; ack = 1'b1;
      repeat (16) cycle();
      ack = 1'b0;
      chk("drain_pending", 128'(pend), 128'(0));
      chk("drain_req", 128'(req), 128'(0));
      chk("drain_ovf_sticky", 128'(ovf), 128'(1));

      // reset mid-frame
      do_reset();
      mc_en = 1'b1; dn_if.ready = 1'b1; up_if.valid = 1'b1;
      up_if.data = rnd_frame(1'b1, 1'b0);
      cycle();
      rst = 1'b1; mc_en = 1'b0;
      cycle();
      chk("rstx_valid", 128'(dn_if.valid), 128'(0));
      chk("rstx_ready", 128'(up_if.ready), 128'(0));
      rst = 1'b0; up_if.valid = 1'b0;
      // reset mid-refresh
      interval = 16'd2; mc_en = 1'b1;
      n = 0;
      while (!req && n < 20) begin cycle(); n++; end
      chk("rstr_req_seen", 128'(req), 128'(1));
      rst = 1'b1; mc_en = 1'b0;
      cycle();
      chk("rstr_req", 128'(req), 128'(0));
      chk("rstr_pending", 128'(pend), 128'(0));
      rst = 1'b0;

      // randomized traffic against the model
      for (int s = 0; s < 4; s++) begin
         do_reset();
         interval = (s == 0) ? 16'd0 : 16'($urandom_range(2, 12));
         gap      = 4'($urandom_range(0, 3));
         repeat (1500) begin
            mc_en       = ($urandom() % 8) != 0;
            up_if.valid = ($urandom() % 3) != 0;
            up_if.data  = rnd_frame(($urandom() % 2) == 0, ($urandom() % 4) == 0);
            dn_if.ready = ($urandom() % 4) != 0;
            ack         = ($urandom() % 3) == 0;
            cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
